// File: rtl/butterfly_job_scheduler_if.sv
// Control/stream handshake bundle between host/DMA, the job scheduler and the butterfly processor.
// master: the environment (host, DMA, processor); slave: the scheduler.
interface butterfly_job_scheduler_if #(
  parameter int unsigned LEN_W = 16,
  parameter int unsigned WB_W  = 16
);
  logic             cmd_vld;
  logic             cmd_rdy;
  logic             cmd_is_fft;
  logic [LEN_W-1:0] cmd_length;
  logic             cmd_bypass_p2s;
  logic [WB_W-1:0]  cmd_wbeats;

  logic             is_fft;
  logic [LEN_W-1:0] length;
  logic             is_bypass_p2s;

  logic             wgt_src_vld;
  logic             wgt_src_rdy;
  logic             wgt_dst_vld;

  logic             in_src_vld;
  logic             in_src_rdy;
  logic             proc_up_rdy;
  logic             proc_up_vld;
  logic             proc_dn_vld;

  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_vld, cmd_is_fft, cmd_length, cmd_bypass_p2s, cmd_wbeats,
    output wgt_src_vld, in_src_vld, proc_up_rdy, proc_dn_vld,
    input  cmd_rdy, is_fft, length, is_bypass_p2s,
    input  wgt_src_rdy, wgt_dst_vld, in_src_rdy, proc_up_vld,
    input  busy, done, err
  );

  modport slave (
    input  cmd_vld, cmd_is_fft, cmd_length, cmd_bypass_p2s, cmd_wbeats,
    input  wgt_src_vld, in_src_vld, proc_up_rdy, proc_dn_vld,
    output cmd_rdy, is_fft, length, is_bypass_p2s,
    output wgt_src_rdy, wgt_dst_vld, in_src_rdy, proc_up_vld,
    output busy, done, err
  );
endinterface

// File: rtl/butterfly_job_scheduler.sv
// Sequences one butterfly job: IDLE -> WLOAD -> STREAM -> DRAIN -> DONE, holding job config stable.
// Optional DRAIN watchdog with sticky err is enabled by defining BFLY_SCHED_TIMEOUT_EN.
module butterfly_job_scheduler #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned WB_W    = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic                      clk,
  input logic                      rst_n,
  butterfly_job_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWload,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic             is_fft_q, is_fft_d;
  logic             bypass_q, bypass_d;
  logic [LEN_W-1:0] length_q, length_d;
  logic [WB_W-1:0]  wbeats_q, wbeats_d;
  logic [WB_W-1:0]  wcnt_q, wcnt_d;
  logic [LEN_W-1:0] icnt_q, icnt_d;
  logic [LEN_W-1:0] ocnt_q, ocnt_d;

  logic wgt_open, in_open;
  logic wgt_fire, in_fire, out_take;
  logic timeout_hit;

  // Zero-beat phases pass nothing through, so their gates stay shut for the single cycle they last.
  assign wgt_open = (state_q == StWload) && (wbeats_q != '0);
  assign in_open  = (state_q == StStream) && (length_q != '0);

  assign wgt_fire = wgt_open & bus.wgt_src_vld;
  assign in_fire  = in_open & bus.in_src_vld & bus.proc_up_rdy;
  assign out_take = ((state_q == StStream) || (state_q == StDrain)) && bus.proc_dn_vld &&
                    (ocnt_q != length_q);

  always_comb begin
    state_d  = state_q;
    is_fft_d = is_fft_q;
    bypass_d = bypass_q;
    length_d = length_q;
    wbeats_d = wbeats_q;
    wcnt_d   = wgt_fire ? wcnt_q + WB_W'(1) : wcnt_q;
    icnt_d   = in_fire ? icnt_q + LEN_W'(1) : icnt_q;
    ocnt_d   = out_take ? ocnt_q + LEN_W'(1) : ocnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_vld) begin
          is_fft_d = bus.cmd_is_fft;
          bypass_d = bus.cmd_bypass_p2s;
          length_d = bus.cmd_length;
          wbeats_d = bus.cmd_wbeats;
          wcnt_d   = '0;
          icnt_d   = '0;
          ocnt_d   = '0;
          state_d  = StWload;
        end
      end
      StWload: begin
        if ((wbeats_q == '0) || (wgt_fire && (wcnt_d == wbeats_q))) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if ((length_q == '0) || (in_fire && (icnt_d == length_q))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if ((ocnt_d == length_q) || timeout_hit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      is_fft_q <= 1'b0;
      bypass_q <= 1'b0;
      length_q <= '0;
      wbeats_q <= '0;
      wcnt_q   <= '0;
      icnt_q   <= '0;
      ocnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      is_fft_q <= is_fft_d;
      bypass_q <= bypass_d;
      length_q <= length_d;
      wbeats_q <= wbeats_d;
      wcnt_q   <= wcnt_d;
      icnt_q   <= icnt_d;
      ocnt_q   <= ocnt_d;
    end
  end

`ifdef BFLY_SCHED_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);

  logic [ToW-1:0] idle_q, idle_d;
  logic           err_q, err_d;

  // idle_d counts cycles since the last output beat (or DRAIN entry), including this one, so
  // DONE lands exactly TIMEOUT cycles after the last beat.
  always_comb begin
    idle_d      = '0;
    timeout_hit = 1'b0;
    if ((state_q == StDrain) && !bus.proc_dn_vld) begin
      idle_d      = idle_q + ToW'(1);
      timeout_hit = (idle_d >= ToW'(TIMEOUT - 1)) && (ocnt_d != length_q);
    end
    err_d = err_q | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign bus.err        = 1'b0;
`endif

  assign bus.cmd_rdy       = (state_q == StIdle);
  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = (state_q == StDone);
  assign bus.is_fft        = is_fft_q;
  assign bus.length        = length_q;
  assign bus.is_bypass_p2s = bypass_q;
  assign bus.wgt_src_rdy   = wgt_open;
  assign bus.wgt_dst_vld   = wgt_fire;
  assign bus.in_src_rdy    = in_open & bus.proc_up_rdy;
  assign bus.proc_up_vld   = in_open & bus.in_src_vld;

endmodule

// File: tb/tb_butterfly_job_scheduler.sv
// Directed bench for butterfly_job_scheduler; cycle numbers are counted from the cmd-accept cycle (c=0).
module tb_butterfly_job_scheduler;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  butterfly_job_scheduler_if #(.LEN_W(16), .WB_W(16)) bus ();

  butterfly_job_scheduler #(
    .LEN_W  (16),
    .WB_W   (16),
    .TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmd_vld        = 1'b0;
    bus.cmd_is_fft     = 1'b0;
    bus.cmd_length     = '0;
    bus.cmd_bypass_p2s = 1'b0;
    bus.cmd_wbeats     = '0;
    bus.wgt_src_vld    = 1'b0;
    bus.in_src_vld     = 1'b0;
    bus.proc_up_rdy    = 1'b0;
    bus.proc_dn_vld    = 1'b0;
  endtask

  task automatic issue(input logic fft, input logic [15:0] len, input logic byp,
                       input logic [15:0] wb);
    bus.cmd_vld        = 1'b1;
    bus.cmd_is_fft     = fft;
    bus.cmd_length     = len;
    bus.cmd_bypass_p2s = byp;
    bus.cmd_wbeats     = wb;
  endtask

  initial begin
    int wgt_n, in_n, done_n, done_c;
    n_total = 0;
    n_bad   = 0;
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_length", 32'(bus.length), 32'd0);
    check("rst_is_fft", 32'(bus.is_fft), 32'd0);

    // Reset mid-STREAM: length=8, 3 beats accepted at c2..c4, reset during c5.
    issue(1'b1, 16'd8, 1'b1, 16'd0);
    bus.in_src_vld  = 1'b1;
    bus.proc_up_rdy = 1'b1;
    in_n = 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      bus.cmd_vld = 1'b0;
      if (c == 5) begin
        bus.in_src_vld = 1'b0;
        rst_n          = 1'b0;
      end
      #1;
      if (bus.in_src_vld && bus.in_src_rdy) in_n++;
      if (c == 1) check("mid_cfg_length", 32'(bus.length), 32'd8);
    end
    check("mid_in_beats", 32'(in_n), 32'd3);
    step();
    rst_n = 1'b1;
    #1;
    check("mid_rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    check("mid_rst_length", 32'(bus.length), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    done_n = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.done) done_n++;
      step();
    end
    check("mid_rst_no_done", 32'(done_n), 32'd0);
    idle_inputs();

    // Full job: wbeats=4, length=16, out beats 5 cycles after inputs (c10..c25), done at c26.
    issue(1'b1, 16'd16, 1'b0, 16'd4);
    bus.wgt_src_vld = 1'b1;
    bus.in_src_vld  = 1'b1;
    bus.proc_up_rdy = 1'b1;
    #1;
    check("job_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    wgt_n  = 0;
    in_n   = 0;
    done_n = 0;
    done_c = -1;
    for (int c = 1; c <= 29; c++) begin
      step();
      bus.cmd_vld     = 1'b0;
      bus.proc_dn_vld = (c >= 10) && (c <= 25);
      #1;
      if (bus.wgt_dst_vld) wgt_n++;
      if (bus.in_src_vld && bus.in_src_rdy) in_n++;
      if (bus.done) begin
        done_n++;
        done_c = c;
      end
      if (c == 1) begin
        check("job_busy", 32'(bus.busy), 32'd1);
        check("job_cfg_is_fft", 32'(bus.is_fft), 32'd1);
      end
    end
    check("job_wgt_beats", 32'(wgt_n), 32'd4);
    check("job_in_beats", 32'(in_n), 32'd16);
    check("job_done_count", 32'(done_n), 32'd1);
    check("job_done_cycle", 32'(done_c), 32'd26);
    check("job_err", 32'(bus.err), 32'd0);
    idle_inputs();
    #1;

    // Minimal job: one cycle per phase, done at c4, cmd_rdy back at c5.
    issue(1'b0, 16'd0, 1'b0, 16'd0);
    #1;
    for (int c = 1; c <= 5; c++) begin
      step();
      bus.cmd_vld = 1'b0;
      #1;
      check($sformatf("min_done_c%0d", c), 32'(bus.done), 32'(c == 4));
      check($sformatf("min_rdy_c%0d", c), 32'(bus.cmd_rdy), 32'(c == 5));
    end

    // proc_up_rdy toggling in STREAM (c2..c12): accepts at even cycles, done at c14.
    issue(1'b0, 16'd6, 1'b0, 16'd0);
    bus.in_src_vld = 1'b1;
    #1;
    in_n   = 0;
    done_c = -1;
    for (int c = 1; c <= 15; c++) begin
      step();
      bus.cmd_vld     = 1'b0;
      bus.proc_up_rdy = (c % 2) == 0;
      bus.proc_dn_vld = (c >= 3) && (c <= 8);
      #1;
      check($sformatf("tog_rdy_c%0d", c), 32'(bus.in_src_rdy),
            32'(((c % 2) == 0) && (c >= 2) && (c <= 12)));
      if (bus.in_src_vld && bus.in_src_rdy) in_n++;
      if (bus.done) done_c = c;
    end
    check("tog_in_beats", 32'(in_n), 32'd6);
    check("tog_done_cycle", 32'(done_c), 32'd14);
    idle_inputs();
    #1;

    // cmd_vld held high: job1 (len 2, wb 1) done at c5, job2 (len 3) accepted at c6, done at c12.
    issue(1'b1, 16'd2, 1'b1, 16'd1);
    bus.wgt_src_vld = 1'b1;
    bus.in_src_vld  = 1'b1;
    bus.proc_up_rdy = 1'b1;
    bus.proc_dn_vld = 1'b1;
    #1;
    done_c = -1;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 1) issue(1'b0, 16'd3, 1'b0, 16'd0);
      if (c == 7) bus.cmd_vld = 1'b0;
      #1;
      if (c <= 5) begin
        check($sformatf("hold_len_c%0d", c), 32'(bus.length), 32'd2);
        check($sformatf("hold_fft_c%0d", c), 32'(bus.is_fft), 32'd1);
        check($sformatf("hold_byp_c%0d", c), 32'(bus.is_bypass_p2s), 32'd1);
        check($sformatf("hold_rdy_c%0d", c), 32'(bus.cmd_rdy), 32'd0);
      end
      if (c == 5) check("hold_done1", 32'(bus.done), 32'd1);
      if (c == 6) check("hold_rdy_c6", 32'(bus.cmd_rdy), 32'd1);
      if (c == 7) begin
        check("hold_len2", 32'(bus.length), 32'd3);
        check("hold_fft2", 32'(bus.is_fft), 32'd0);
      end
      if ((c > 5) && bus.done) done_c = c;
    end
    check("hold_done2_cycle", 32'(done_c), 32'd12);
    idle_inputs();
    #1;

`ifdef BFLY_SCHED_TIMEOUT_EN
    // Watchdog: length=4, out beats only at c6,c7 (DRAIN) -> err and done at c23.
    issue(1'b0, 16'd4, 1'b0, 16'd0);
    bus.in_src_vld  = 1'b1;
    bus.proc_up_rdy = 1'b1;
    #1;
    done_c = -1;
    for (int c = 1; c <= 25; c++) begin
      step();
      bus.cmd_vld     = 1'b0;
      bus.proc_dn_vld = (c == 6) || (c == 7);
      #1;
      if (bus.done && (done_c < 0)) done_c = c;
      if (c == 22) check("to_err_before", 32'(bus.err), 32'd0);
      if (c == 23) check("to_err_at_done", 32'(bus.err), 32'd1);
    end
    check("to_done_cycle", 32'(done_c), 32'd23);
    check("to_err_sticky", 32'(bus.err), 32'd1);
    idle_inputs();
`else
    check("no_to_err", 32'(bus.err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
